// File: rtl/riscv_alu_pkg.sv
//------------------------------------------------------------------------------
// Module   : riscv_alu_pkg
// Purpose  : Shared types and constants for the execute-stage divide unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_alu_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam int DIV_N_DEFAULT = 64;

  // Counter must hold the value N itself, hence one bit beyond log2.
  function automatic int div_cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_N_DEFAULT);

endpackage

`default_nettype wire

// File: rtl/riscv_div_unit_if.sv
//------------------------------------------------------------------------------
// Module   : riscv_div_unit_if
// Purpose  : Request/response bundle between the pipeline and the divide unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface riscv_div_unit_if
  import riscv_alu_pkg::*;
#(
  parameter int N = 64
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  div_op_t        op;
  logic           wArith;
  logic           busy;
  logic           done;
  logic [N-1:0]   result;

  modport master (
    output start, a, b, op, wArith,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b, op, wArith,
    output busy, done, result
  );
endinterface

`default_nettype wire

// File: rtl/riscv_div_step.sv
//------------------------------------------------------------------------------
// Module   : riscv_div_step
// Purpose  : One combinational restoring-division step on {rem, quo}.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module riscv_div_step #(
  parameter int N = 64
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] quo,
  input  logic [N-1:0] dvs,
  output logic [N-1:0] rem_next,
  output logic [N-1:0] quo_next
);

  // Shifted partial remainder can reach 2*dvs-1, so one extra bit is needed.
  logic [N:0] w_trial;
  logic [N:0] w_diff;

  assign w_trial  = {rem, quo[N-1]};
  assign w_diff   = w_trial - {1'b0, dvs};
  assign quo_next = {quo[N-2:0], ~w_diff[N]};
  assign rem_next = w_diff[N] ? w_trial[N-1:0] : w_diff[N-1:0];

endmodule

`default_nettype wire

// File: rtl/riscv_div_unit.sv
//------------------------------------------------------------------------------
// Module   : riscv_div_unit
// Purpose  : Iterative RV64M DIV/DIVU/REM/REMU (+W forms), one bit per clock.
//            RISCV_DIV_EARLY_OUT_EN: divide-by-zero/overflow skip iteration.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module riscv_div_unit
  import riscv_alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic            clk,
  input  logic            reset,
  riscv_div_unit_if.slave bus
);

  localparam int HALF  = N / 2;
  localparam int CNT_W = div_cnt_w(N);

  div_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [N-1:0]       r_rem;
  logic [N-1:0]       r_quo;
  logic [N-1:0]       r_dvs;
  logic [N-1:0]       r_dvd;
  div_op_t            r_op;
  logic               r_w;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;
  logic [N-1:0]       r_result;

  logic               w_signed;
  logic [N-1:0]       w_a_ext;
  logic [N-1:0]       w_b_ext;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [N-1:0]       w_a_mag;
  logic [N-1:0]       w_b_mag;
  logic [N-1:0]       w_most_neg;
  logic               w_div0;
  logic               w_ovf;
  logic               w_is_rem;
  logic [N-1:0]       w_rem_nx;
  logic [N-1:0]       w_quo_nx;

  // Operand conditioning: width selection, extension and magnitude.
  always_comb begin
    w_signed = (bus.op == OP_DIV) || (bus.op == OP_REM);
    if (bus.wArith) begin
      w_a_ext    = {{HALF{w_signed & bus.a[HALF-1]}}, bus.a[HALF-1:0]};
      w_b_ext    = {{HALF{w_signed & bus.b[HALF-1]}}, bus.b[HALF-1:0]};
      w_most_neg = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      w_a_ext    = bus.a;
      w_b_ext    = bus.b;
      w_most_neg = {1'b1, {(N-1){1'b0}}};
    end
    w_a_neg = w_signed & w_a_ext[N-1];
    w_b_neg = w_signed & w_b_ext[N-1];
    w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    w_div0  = (w_b_ext == '0);
    w_ovf   = w_signed & (w_a_ext == w_most_neg) & (w_b_ext == '1);
  end

  assign w_is_rem = (r_op == OP_REM) || (r_op == OP_REMU);

  riscv_div_step #(.N(N)) u_step (
    .rem      (r_rem),
    .quo      (r_quo),
    .dvs      (r_dvs),
    .rem_next (w_rem_nx),
    .quo_next (w_quo_nx)
  );

  // Sign fix-up, special-case override, select and W-form sign extension.
  function automatic logic [N-1:0] form_result(
    input logic [N-1:0] quo,
    input logic [N-1:0] rem,
    input logic [N-1:0] dvd,
    input logic         neg_q,
    input logic         neg_r,
    input logic         div0,
    input logic         ovf,
    input logic         is_rem,
    input logic         w
  );
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic [N-1:0] sel;
    q = neg_q ? -quo : quo;
    r = neg_r ? -rem : rem;
    if (div0) begin
      q = '1;
      r = dvd;
    end else if (ovf) begin
      q = dvd;
      r = '0;
    end
    sel = is_rem ? r : q;
    if (w) sel = {{HALF{sel[HALF-1]}}, sel[HALF-1:0]};
    return sel;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_dvd    <= '0;
      r_op     <= OP_DIV;
      r_w      <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_w     <= bus.wArith;
            r_dvd   <= w_a_ext;
            r_dvs   <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_div0  <= w_div0;
            r_ovf   <= w_ovf;
            r_rem   <= '0;
            // W dividend sits in the upper half so it shifts out after N/2 steps.
            r_quo   <= bus.wArith ? (w_a_mag << HALF) : w_a_mag;
            r_cnt   <= bus.wArith ? CNT_W'(HALF) : CNT_W'(N);
            r_busy  <= 1'b1;
`ifdef RISCV_DIV_EARLY_OUT_EN
            if (w_div0 || w_ovf) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_result <= form_result('0, '0, w_a_ext, 1'b0, 1'b0, w_div0, w_ovf,
                                      (bus.op == OP_REM) || (bus.op == OP_REMU),
                                      bus.wArith);
            end else begin
              r_state <= ST_CALC;
            end
`else
            r_state <= ST_CALC;
`endif
          end
        end

        ST_CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_result <= form_result(w_quo_nx, w_rem_nx, r_dvd, r_neg_q, r_neg_r,
                                    r_div0, r_ovf, w_is_rem, r_w);
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

`default_nettype wire

// File: doc/riscv_div_unit.md
# riscv_div_unit

Iterative RV64M divide/remainder unit beside the integer ALU in the execute stage. Performs DIV, DIVU, REM and REMU, plus the 32-bit W forms, with one restoring-division step per clock. The pipeline stalls on `busy` and captures `result` on the `done` pulse. Outputs follow RISC-V rules for divide-by-zero and signed overflow.

## Interface
- `N`, default 64: datapath width; must be even. W forms use the low N/2 bits.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request; accepted only when `busy`=0.
- `a` in N: dividend.
- `b` in N: divisor.
- `op` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `wArith` in 1: W form (DIVW/DIVUW/REMW/REMUW).
- `busy` out 1: operation in flight; new `start` ignored.
- `done` out 1: one-cycle pulse; `result` valid.
- `result` out N: quotient or remainder, held until the next accepted `start`.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `start`=1:
  - Latch `op` and `wArith`.
  - W form: operands are `a[N/2-1:0]` and `b[N/2-1:0]`, sign- or zero-extended per `op`.
  - Signed ops: record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a); divide magnitudes.
  - Load iteration counter with N, or N/2 for W. Go to CALC.
- CALC, each cycle:
  - Shift {rem, quo} left by one.
  - Trial-subtract the divisor magnitude from rem.
  - If the result is non-negative, keep it and set quo LSB.
  - Decrement the counter. At 1, go to DONE.
- DONE:
  - Negate quotient/remainder per the recorded signs.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU).
  - W form: sign-extend bit N/2-1 to N bits, including DIVUW/REMUW.
  - Register `result`, pulse `done`, return to IDLE.
- Special cases, operand width per `wArith`:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed, dividend = most-negative, divisor = -1: quotient = dividend; remainder = 0.
- `start` while `busy`=1: ignored; no queuing.
- `start` in IDLE in the same cycle `done` pulses: impossible, since `done` is only high in DONE.
- Reset mid-operation: abort to IDLE; no `done` pulse.
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE.

## Timing
- `start` is sampled at edge k.
  - `busy`=1 from k+1 through the DONE cycle.
  - Full-width: CALC occupies cycles k+1..k+N; `done`=1 in cycle k+N+1 (k+65 for N=64).
  - W form: `done`=1 in cycle k+N/2+1 (k+33).
- `busy` falls in the same cycle that `done`=0 again.
- A new `start` can be accepted in the cycle after `done`.
- Latency is data-independent except as allowed by the macro below.
- There is no combinational path from `start`, `a` or `b` to any output.

## Configuration
- `RISCV_DIV_EARLY_OUT_EN` defined:
  - Divide-by-zero and signed overflow skip CALC: IDLE goes directly to DONE.
  - `done`=1 in cycle k+1.
- Macro undefined:
  - Special cases run the full CALC sequence.
  - Their result is forced in DONE; latency is identical to normal divides.
- Results are bit-identical either way.

## Structure
- Shared package `riscv_alu_pkg`:
  - `div_op_t` enum (DIV, DIVU, REM, REMU).
  - `div_state_t` enum (IDLE, CALC, DONE).
  - Constant `DIV_CNT_W` = $clog2(N)+1.
- Sub-module `riscv_div_step`: combinational single restoring step.
  - Inputs: rem, quo, divisor magnitude.
  - Outputs: next rem, next quo.
  - Instantiated once inside `riscv_div_unit`.

## Test plan
- DIVU a=100, b=7 -> `result`=14 with `done` exactly 65 cycles after `start`; REMU same operands -> 2.
- DIV a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU b=0, a=5 -> all ones; REM b=0, a=-9 -> -9. Latency checked with and without `RISCV_DIV_EARLY_OUT_EN` (1 vs 65 cycles).
- DIV a=0x8000_0000_0000_0000, b=-1 -> a, REM -> 0. DIVW a=0x8000_0000, b=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 with `done` at 33 cycles.
- DIVUW a=0xFFFF_FFFF, b=1 -> 0xFFFF_FFFF_FFFF_FFFF (sign-extended). A second `start` with new operands while `busy` -> ignored; first result returned.
- Assert `reset` at CALC cycle 20 -> next cycle `busy`=0, `done`=0, `result`=0. A fresh DIVU 9/3 then returns 3.
